sr_cmd_sequencer: RTL
=====================

// Module: sr_cmd_sequencer
// PURPOSE
//  - Upstream driver stage for the SR flip-flop. Accepts set/reset/toggle commands
//    over a valid/ready handshake and turns each into a clean S or R pulse.
//  - Each pulse is fixed-width and is followed by a guard gap.
//  - S and R are never both high. This keeps the downstream SR flip-flop out of its invalid state.
//  - Keeps a shadow copy of the expected flip-flop output (q_exp). Toggle commands use it;
//    benches check the downstream Q against it.
// PARAMETERS
//  PULSE_CYCLES  2  clock cycles S or R stays high per command; 0 is treated as 1
//  GAP_CYCLES    1  idle cycles (S=R=0, not ready) after each pulse; 0 allowed
//  CNT_W         8  width of the phase counter; PULSE_CYCLES and GAP_CYCLES must be < 2**CNT_W
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  cmd_valid  in   1  command present on cmd_op
//  cmd_op     in   2  00=NOP, 01=SET, 10=RESET, 11=TOGGLE
//  cmd_ready  out  1  block can accept a command; high only in IDLE
//  S          out  1  set drive to the SR flip-flop, registered
//  R          out  1  reset drive to the SR flip-flop, registered
//  busy       out  1  high in DRIVE or GAP
//  q_exp      out  1  expected flip-flop Q after the last completed pulse
// BEHAVIOUR
//  - Reset, asserted asynchronously:
//    - state=IDLE, counter=0, S=0, R=0, busy=0, q_exp=0, cmd_ready=1.
//    - Reset during DRIVE drops S/R at once and discards the command in flight.
//  - Handshake:
//    - A command is accepted on the rising edge where cmd_valid && cmd_ready.
//    - cmd_op is sampled only at acceptance; later changes to cmd_op are ignored.
//    - cmd_ready = (state==IDLE). It is combinational from state only, not from cmd_valid.
//  - Op resolution at acceptance:
//    - SET -> drive S.
//    - RESET -> drive R.
//    - TOGGLE -> drive R if q_exp==1, else drive S.
//    - NOP -> accepted, state stays IDLE, no output activity.
//  - FSM states: IDLE, DRIVE, GAP.
//    - IDLE -> DRIVE on accepting a non-NOP command. Counter loads PULSE_CYCLES-1
//      (or 0 if PULSE_CYCLES==0).
//    - DRIVE: the selected S or R is high. Counter counts down by 1 per cycle.
//    - DRIVE exit when counter==0:
//      - q_exp <= 1 for an S pulse, 0 for an R pulse.
//      - If GAP_CYCLES>0: go to GAP with counter=GAP_CYCLES-1. Otherwise go to IDLE.
//    - GAP: S=R=0, busy=1. Go to IDLE when counter==0.
//  - Latency: S/R go high on the first cycle after the accepting edge.
//    They stay high for exactly max(PULSE_CYCLES,1) cycles.
//  - Command throughput: one command per max(P,1)+GAP_CYCLES+1 cycles,
//    where P=PULSE_CYCLES. The +1 is the IDLE accept cycle.
//  - Invariant: S&R==0 in every cycle, including reset entry and exit.
//  - SET while q_exp is already 1 still produces a full S pulse; no suppression.
//  - Holding cmd_valid high back-to-back gives a new acceptance each time the FSM
//    returns to IDLE.
// TESTING
//  - Params 2/1.
//    - Stimulus: reset released; SET accepted at edge t0.
//    - Response: S=1 during cycles t0+1 and t0+2; R=0 throughout; GAP at t0+3;
//      cmd_ready=1 at t0+4; q_exp=1 from t0+3.
//  - Params 2/1.
//    - Stimulus: TOGGLE with q_exp=1, then TOGGLE again.
//    - Response: first command gives a 2-cycle R pulse and q_exp=0; second gives a
//      2-cycle S pulse and q_exp=1; commands are accepted 4 cycles apart.
//  - Stimulus: NOP with cmd_valid held for 3 cycles.
//    - Response: 3 acceptances; S=R=0; busy=0; cmd_ready stays 1.
//  - Stimulus: cmd_valid=1, cmd_op=RESET asserted while busy; cmd_op changed to SET
//    during DRIVE.
//    - Response: no acceptance until IDLE; then a RESET is accepted only if cmd_op
//      still reads 10 at that edge.
//  - Stimulus: rst_n pulled low mid-DRIVE of an S pulse.
//    - Response: S falls in the same cycle without waiting for clk; q_exp=0.
//      After release: IDLE, cmd_ready=1.
//  - Params PULSE_CYCLES=0, GAP_CYCLES=0.
//    - Stimulus: SET then RESET, back-to-back.
//    - Response: S for 1 cycle, then R for 1 cycle.
//    - Check S&R==0 on every cycle of every test.

Source files
------------

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer
//   Front end for a downstream SR flip-flop. Takes SET / RESET / TOGGLE
//   commands over a valid/ready handshake. Each command becomes one
//   fixed-width S or R pulse, followed by an idle guard gap. S and R are
//   never high together. q_exp holds a shadow copy of the flip-flop output
//   that the downstream Q is expected to show.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command present on cmd_op
//   cmd_op     in   [1:0] 00=NOP 01=SET 10=RESET 11=TOGGLE
//   cmd_ready  out  high only in IDLE (decoded from state alone)
//   S, R       out  registered set/reset drives
//   busy       out  high in DRIVE or GAP
//   q_exp      out  expected flip-flop Q after the last completed pulse
module sr_cmd_sequencer #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       S,
    output logic       R,
    output logic       busy,
    output logic       q_exp
);

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_RESET  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    // A zero pulse width still produces a one-cycle pulse.
    localparam logic [CNT_W-1:0] PULSE_LOAD =
        (PULSE_CYCLES == 0) ? '0 : CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sel_s_reg, sel_s_next;   // 1: current pulse is S, 0: R
    logic             q_exp_reg, q_exp_next;
    logic             s_reg, s_next;
    logic             r_reg, r_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sel_s_reg <= 1'b0;
            q_exp_reg <= 1'b0;
            s_reg     <= 1'b0;
            r_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_s_reg <= sel_s_next;
            q_exp_reg <= q_exp_next;
            s_reg     <= s_next;
            r_reg     <= r_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_s_next = sel_s_reg;
        q_exp_next = q_exp_reg;

        case (state_reg)
            IDLE: begin
                // NOP is accepted (ready is high) but starts nothing.
                if (cmd_valid && (cmd_op != OP_NOP)) begin
                    state_next = DRIVE;
                    cnt_next   = PULSE_LOAD;
                    sel_s_next = (cmd_op == OP_SET) ||
                                 ((cmd_op == OP_TOGGLE) && !q_exp_reg);
                end
            end
            DRIVE: begin
                if (cnt_reg == '0) begin
                    q_exp_next = sel_s_reg;
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Registered outputs follow the next state, so the pulse lines up
        // exactly with the DRIVE cycles and both lines are mutually exclusive.
        s_next = (state_next == DRIVE) && sel_s_next;
        r_next = (state_next == DRIVE) && !sel_s_next;
    end

    // OP_RESET is implied by the selection logic; referenced to keep the
    // encoding table complete for readers.
    logic unused_op_reset;
    assign unused_op_reset = (cmd_op == OP_RESET);

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign S         = s_reg;
    assign R         = r_reg;
    assign q_exp     = q_exp_reg;

endmodule
